// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port Avalon-MM arbiter in front of one SDRAM master port.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module sdram_arbiter #(
  parameter int MAX_PENDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s0_address,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [31:0] s0_writedata,
  output logic        s0_waitrequest,
  output logic [31:0] s0_readdata,
  output logic        s0_readdatavalid,
  input  logic [31:0] s1_address,
  input  logic        s1_read,
  input  logic        s1_write,
  input  logic [31:0] s1_writedata,
  output logic        s1_waitrequest,
  output logic [31:0] s1_readdata,
  output logic        s1_readdatavalid,
  output logic [31:0] master_address,
  output logic        master_read,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        err_unexp
);

  localparam int AW = $clog2(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                 r_state;
  logic                   r_last;
  logic [MAX_PENDING-1:0] r_owner;
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_count;
  logic                   r_err;

  logic w_req0, w_req1, w_any;
  logic w_g0, w_g1;
  logic w_sel_read, w_sel_write, w_sel_req;
  logic w_full, w_empty, w_block;
  logic w_accept, w_push, w_pop, w_head;
  logic w_pick;

  assign w_req0 = s0_read | s0_write;
  assign w_req1 = s1_read | s1_write;
  assign w_any  = w_req0 | w_req1;
  assign w_g0   = (r_state == GRANT0);
  assign w_g1   = (r_state == GRANT1);

  // A simultaneous read and write is resolved as a read.
  assign w_sel_read  = (w_g0 & s0_read) | (w_g1 & s1_read);
  assign w_sel_write = (w_g0 & s0_write & ~s0_read)
                     | (w_g1 & s1_write & ~s1_read);
  assign w_sel_req   = w_sel_read | w_sel_write;

  assign w_full   = (r_count == (AW+1)'(MAX_PENDING));
  assign w_empty  = (r_count == '0);
  assign w_block  = w_sel_read & w_full;
  assign w_accept = w_sel_req & ~master_waitrequest & ~w_block;
  assign w_push   = w_accept & w_sel_read;
  assign w_pop    = master_readdatavalid & ~w_empty;
  assign w_head   = r_owner[r_rptr];

`ifdef ARB_FIXED_PRIO_EN
  assign w_pick = ~w_req0;
`else
  logic w_last_eff;
  // On an accept the port just served loses the next tie.
  assign w_last_eff = w_accept ? w_g1 : r_last;
  assign w_pick = (w_req0 & w_req1) ? ~w_last_eff : ~w_req0;
`endif

  assign master_address   = w_g1 ? s1_address : s0_address;
  assign master_writedata = w_g1 ? s1_writedata : s0_writedata;
  assign master_read      = w_sel_read & ~w_block;
  assign master_write     = w_sel_write;

  assign s0_waitrequest = w_g0 ? (master_waitrequest | w_block) : 1'b1;
  assign s1_waitrequest = w_g1 ? (master_waitrequest | w_block) : 1'b1;

  assign s0_readdata      = master_readdata;
  assign s1_readdata      = master_readdata;
  assign s0_readdatavalid = w_pop & ~w_head;
  assign s1_readdatavalid = w_pop & w_head;
  assign err_unexp        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_owner <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept || !w_sel_req) begin
        if (!w_any)
          r_state <= IDLE;
        else
          r_state <= w_pick ? GRANT1 : GRANT0;
      end
      if (w_accept)
        r_last <= w_g1;
      if (w_push) begin
        r_owner[r_wptr] <= w_g1;
        r_wptr          <= r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (master_readdatavalid && w_empty)
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter
// against a requester/SDRAM scoreboard model.
module tb_sdram_arbiter;

  localparam int MP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_address, s1_address;
  logic        s0_read, s1_read, s0_write, s1_write;
  logic [31:0] s0_writedata, s1_writedata;
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic [31:0] master_address, master_writedata, master_readdata;
  logic        master_read, master_write;
  logic        master_waitrequest, master_readdatavalid;
  logic        err_unexp;

  always #5 clk = ~clk;

  sdram_arbiter #(.MAX_PENDING(MP)) dut (
    .clk(clk), .rst(rst),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest),
    .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .err_unexp(err_unexp)
  );

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int last_acc = -1;

  tx_t q0[$];
  tx_t q1[$];
  tx_t cur[2];
  logic act[2];
  int gap[2];
  int starve[2];

  logic [31:0] expd0[$];
  logic [31:0] expd1[$];
  int oq[$];
  int rdue[$];
  logic [31:0] rdat[$];
  int last_due = 0;

  int mw_pct = 0;
  int lat_min = 2;
  int lat_max = 2;
  int gap_max = 0;
  logic hold_rdv = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic tx_t mk(input logic rd, input logic [31:0] a,
                             input logic [31:0] d);
    tx_t t;
    t.rd = rd;
    t.addr = a;
    t.data = d;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s0_read = 1'b0; s0_write = 1'b0; s0_address = '0; s0_writedata = '0;
    s1_read = 1'b0; s1_write = 1'b0; s1_address = '0; s1_writedata = '0;
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_wait0", s0_waitrequest, 1'b1);
    chk1("rst_wait1", s1_waitrequest, 1'b1);
    chk1("rst_mread", master_read, 1'b0);
    chk1("rst_mwrite", master_write, 1'b0);
    chk1("rst_err", err_unexp, 1'b0);
    chk1("rst_rdv0", s0_readdatavalid, 1'b0);
    chk1("rst_rdv1", s1_readdatavalid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      gap[i] = 0;
      starve[i] = 0;
      cur[i] = '0;
    end
    last_due = cyc;
  endtask

  // One clock: requesters and SDRAM drive at negedge, everything checked 1ns later.
  task automatic tick();
    logic a0, a1, r0, r1, rdv, macc;
    int own, p, due;
    logic [31:0] d;
    @(negedge clk);
    cyc++;
    last_acc = -1;
    if (!act[0] && q0.size() > 0) begin
      if (gap[0] > 0) gap[0]--;
      else begin cur[0] = q0.pop_front(); act[0] = 1'b1; end
    end
    if (!act[1] && q1.size() > 0) begin
      if (gap[1] > 0) gap[1]--;
      else begin cur[1] = q1.pop_front(); act[1] = 1'b1; end
    end
    r0 = act[0];
    r1 = act[1];
    s0_read = r0 & cur[0].rd;
    s0_write = r0 & ~cur[0].rd;
    s0_address = cur[0].addr;
    s0_writedata = cur[0].data;
    s1_read = r1 & cur[1].rd;
    s1_write = r1 & ~cur[1].rd;
    s1_address = cur[1].addr;
    s1_writedata = cur[1].data;
    master_waitrequest = ($urandom_range(99) < mw_pct);
    rdv = !hold_rdv && rdue.size() > 0 && rdue[0] <= cyc;
    master_readdatavalid = rdv;
    master_readdata = rdv ? rdat[0] : $urandom();
    #1;
    if (rdv) begin
      own = oq.pop_front();
      void'(rdue.pop_front());
      void'(rdat.pop_front());
      chk1("route_rdv0", s0_readdatavalid, own == 0);
      chk1("route_rdv1", s1_readdatavalid, own == 1);
      if (own == 0) begin
        d = expd0.pop_front();
        chk("rdata0", s0_readdata, d);
      end else begin
        d = expd1.pop_front();
        chk("rdata1", s1_readdata, d);
      end
    end else begin
      chk1("idle_rdv0", s0_readdatavalid, 1'b0);
      chk1("idle_rdv1", s1_readdatavalid, 1'b0);
    end
    a0 = r0 & ~s0_waitrequest;
    a1 = r1 & ~s1_waitrequest;
    macc = (master_read | master_write) & ~master_waitrequest;
    chk1("single_acc", a0 & a1, 1'b0);
    chk1("acc_match", macc, a0 | a1);
    if (a0 | a1) begin
      p = a0 ? 0 : 1;
      chk("m_addr", master_address, cur[p].addr);
      chk1("m_read", master_read, cur[p].rd);
      chk1("m_write", master_write, ~cur[p].rd);
      if (cur[p].rd) begin
        oq.push_back(p);
        if (p == 0) expd0.push_back(mem(cur[p].addr));
        else expd1.push_back(mem(cur[p].addr));
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due < last_due) due = last_due;
        last_due = due;
        rdue.push_back(due);
        rdat.push_back(mem(master_address));
      end else begin
        chk("m_wdata", master_writedata, cur[p].data);
      end
      act[p] = 1'b0;
      gap[p] = int'($urandom_range(gap_max, 0));
      last_acc = p;
      n_acc++;
    end
`ifndef ARB_FIXED_PRIO_EN
    // A waiting port may see at most one transfer of the other port.
    if (r0 && !a0 && a1) starve[0]++;
    else if (!r0 || a0) starve[0] = 0;
    if (r1 && !a1 && a0) starve[1]++;
    else if (!r1 || a1) starve[1] = 0;
    chk1("starve0", starve[0] <= 1, 1'b1);
    chk1("starve1", starve[1] <= 1, 1'b1);
`endif
    chk1("outstanding", oq.size() <= MP, 1'b1);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + rdue.size()) != 0 || act[0] || act[1]) begin
      tick();
      n++;
      if (n > lim) break;
    end
    chk1("drain_done", n <= lim, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, base, nseq;
    int seq[$];
    int sc[$];
    logic [31:0] expv;

    // Reset and single write stalled by SDRAM for three cycles.
    do_reset();
    @(negedge clk);
    s0_address = 32'hAAAA_1110;
    s0_writedata = 32'h1234_5678;
    s0_write = 1'b1;
    master_waitrequest = 1'b1;
    #1;
    chk1("wr_idle_mwrite", master_write, 1'b0);
    chk1("wr_idle_wait0", s0_waitrequest, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      master_waitrequest = (k < 3);
      #1;
      chk1("wr_mwrite", master_write, 1'b1);
      chk("wr_maddr", master_address, 32'hAAAA_1110);
      chk("wr_mwdata", master_writedata, 32'h1234_5678);
      chk1("wr_wait0", s0_waitrequest, k < 3);
      chk1("wr_wait1", s1_waitrequest, 1'b1);
    end
    @(negedge clk);
    s0_write = 1'b0;
    master_waitrequest = 1'b0;
    #1;
    chk1("wr_drop_mwrite", master_write, 1'b0);

    // Both ports stream four reads each, SDRAM latency 2.
    do_reset();
    mw_pct = 0; lat_min = 2; lat_max = 2; gap_max = 0;
    for (int k = 0; k < 4; k++) begin
      q0.push_back(mk(1'b1, 32'h0000_1000 + 32'(k * 4), '0));
      q1.push_back(mk(1'b1, 32'h0000_2000 + 32'(k * 4), '0));
    end
    c0 = cyc;
    for (int n = 0; n < 40 && seq.size() < 8; n++) begin
      tick();
      if (last_acc >= 0) begin
        seq.push_back(last_acc);
        sc.push_back(cyc);
      end
    end
    nseq = seq.size();
    chk("alt_count", 32'(nseq), 32'd8);
    if (nseq == 8) begin
      chk("grant_latency", 32'(sc[0] - c0), 32'd2);
      for (int k = 0; k < 8; k++) begin
`ifdef ARB_FIXED_PRIO_EN
        expv = (k < 4) ? 32'd0 : 32'd1;
`else
        expv = 32'(k % 2);
        chk("alt_no_bubble", 32'(sc[k] - sc[0]), 32'(k));
`endif
        chk("alt_grant", 32'(seq[k]), expv);
      end
    end
    drain(100);

    // Owner FIFO fills: ninth read held until one response returns.
    do_reset();
    mw_pct = 0; lat_min = 1; lat_max = 1; gap_max = 0;
    hold_rdv = 1'b1;
    for (int k = 0; k < 9; k++)
      q0.push_back(mk(1'b1, 32'h0000_3000 + 32'(k), '0));
    base = n_acc;
    for (int n = 0; n < 40 && (n_acc - base) < 8; n++) tick();
    chk("full_accepts", 32'(n_acc - base), 32'd8);
    repeat (3) begin
      tick();
      chk1("full_wait0", s0_waitrequest, 1'b1);
      chk1("full_mread", master_read, 1'b0);
    end
    hold_rdv = 1'b0;
    tick();
    chk1("pop_cycle_wait0", s0_waitrequest, 1'b1);
    tick();
    chk("ninth_accept", 32'(last_acc), 32'd0);
    chk1("ninth_mread", master_read, 1'b1);
    drain(100);

    // Randomized mixed traffic with random stalls, gaps and latency.
    do_reset();
    mw_pct = 25; lat_min = 1; lat_max = 5; gap_max = 2;
    for (int k = 0; k < 30; k++) begin
      q0.push_back(mk(1'($urandom_range(1)), $urandom(), $urandom()));
      q1.push_back(mk(1'($urandom_range(1)), $urandom(), $urandom()));
    end
    base = n_acc;
    drain(4000);
    chk("rand_accepts", 32'(n_acc - base), 32'd60);

    // Unexpected response with nothing outstanding.
    do_reset();
    @(negedge clk);
    master_readdatavalid = 1'b1;
    master_readdata = 32'hDEAD_BEEF;
    #1;
    chk1("unexp_rdv0", s0_readdatavalid, 1'b0);
    chk1("unexp_rdv1", s1_readdatavalid, 1'b0);
    chk1("unexp_err_pre", err_unexp, 1'b0);
    @(negedge clk);
    master_readdatavalid = 1'b0;
    #1;
    chk1("unexp_err", err_unexp, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk1("unexp_sticky", err_unexp, 1'b1);
    end
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port round-robin arbiter sharing the single SDRAM-facing Avalon-MM master port between two accelerator masters (wordcopy and the DNN dot-product engine). Forwards one granted requester's read/write to the SDRAM port, stalls the other with waitrequest, and routes pipelined read responses back to their issuer through an owner-ID FIFO. Sits between the accelerators' master ports and the SDRAM controller.

## Interface
Parameters:
- MAX_PENDING, 8: maximum outstanding reads (owner FIFO depth), power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s0_address / s1_address  in  32  requester word address
- s0_read / s1_read  in  1  read request
- s0_write / s1_write  in  1  write request
- s0_writedata / s1_writedata  in  32  write data
- s0_waitrequest / s1_waitrequest  out  1  stall to requester
- s0_readdata / s1_readdata  out  32  read data (both driven from master_readdata)
- s0_readdatavalid / s1_readdatavalid  out  1  read data valid, routed by owner
- master_address  out  32  to SDRAM
- master_read / master_write  out  1  to SDRAM
- master_writedata  out  32  to SDRAM
- master_waitrequest  in  1  from SDRAM
- master_readdata  in  32  from SDRAM
- master_readdatavalid  in  1  from SDRAM
- err_unexp  out  1  sticky: readdatavalid arrived with owner FIFO empty

## Operation
- States: IDLE, GRANT0, GRANT1 (registered). req_i = s_i_read | s_i_write.
- IDLE: no forwarding; master_read/master_write = 0; both s_i_waitrequest = 1. At edge, if any req_i: go GRANTi per arbitration; else stay.
- GRANTi: master_* driven from port i combinationally; s_i_waitrequest = master_waitrequest | block; other port waitrequest = 1. block = s_i_read & fifo_full; when block, master_read forced 0.
- Accept = GRANTi & req_i & !master_waitrequest & !block. On accept edge: rearbitrate (next grant chosen among current req inputs, round-robin favouring the port not just served); if no req, IDLE.
- GRANTi with req_i = 0 (requester dropped): next edge rearbitrate as from IDLE.
- Round-robin pointer last_served updated on each accept only. Ties in IDLE: port ≠ last_served wins.
- Read accept pushes i into owner FIFO. master_readdatavalid pops head h; s_h_readdatavalid = 1 same cycle (combinational from FIFO head). Push and pop same cycle allowed; push blocked whenever FIFO is full at cycle start, irrespective of pop.
- readdatavalid with FIFO empty: dropped (neither s_i_readdatavalid asserted), err_unexp set until rst.
- s0_read and s0_write both high is illegal; read takes priority.

## Timing
- Reset values: state IDLE, last_served = 1 (port 0 wins first tie), FIFO empty, err_unexp 0, master_read/master_write 0, s0/s1_waitrequest 1, s_i_readdatavalid 0. readdata outputs mirror master_readdata unconditionally.
- Grant latency: request first seen at edge N → forwarded to SDRAM in cycle N+1.
- Back-to-back from same requester with other idle: no bubble (rearbitration on accept regrants same port).
- Alternating requesters both continuously requesting: grants alternate every accepted transfer, zero idle cycles.
- Read response latency added by arbiter: 0 cycles.
- rst mid-transfer: all state cleared at edge; in-flight SDRAM responses arriving after reset set err_unexp (bench must drain before reset).

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins any contention, last_served ignored (port 1 can starve).
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold rst 2 cycles → all waitrequests 1, master_read/write 0, err_unexp 0.
- s0 single write addr 0xAAAA1110 data 0x12345678, master_waitrequest high 3 cycles → master_write high 4 cycles with those values, s0_waitrequest falls in 4th, s1_waitrequest stays 1.
- s0 and s1 both issue 4 reads continuously, SDRAM returns each 2 cycles later → grants 0,1,0,1,...; readdatavalid routed in issue order; no idle cycle on master_read.
- MAX_PENDING=8, SDRAM withholds readdatavalid: 8 reads accepted, 9th held (s_i_waitrequest 1, master_read 0) until one readdatavalid → 9th accepted next cycle.
- Inject master_readdatavalid with empty FIFO → both s_i_readdatavalid 0, err_unexp 1 and sticky until rst.
- With ARB_FIXED_PRIO_EN: s0 and s1 both requesting continuously → s1 never granted while s0 requests.
